// File: rtl/adr_pkg.sv
// Shared definitions for the ADR mode/complete latch: FSM state encoding and
// default trigger/timeout constants.
package adr_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RSM   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ARMED = 2'd2,
    ST_S5    = 2'd3
  } adr_state_t;

  localparam logic [7:0] BIOS_LATCH_CODE_DEF = 8'hB0;
  localparam int         TIMEOUT_2MHZ_1S     = 2000000;

endpackage

// File: rtl/adr_sync.sv
// Generic N-stage flop synchroniser with asynchronous reset to RST_VAL.
module adr_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/adr_latch_multi.sv
// ADR mode/complete latch: captures PCH ADR mode straps once the BIOS post code
// is stable, gates ADR-complete until capture. Optional WAIT timeout: ADR_LATCH_TIMEOUT_EN.
module adr_latch_multi
  import adr_pkg::*;
#(
  parameter int                MODE_W          = 2,
  parameter int                CMPL_N          = 1,
  parameter logic [7:0]        LATCH_CODE      = BIOS_LATCH_CODE_DEF,
  parameter int                CODE_STABLE_CYC = 4,
  parameter int                SYNC_STAGES     = 2,
  parameter int                TIMEOUT_CYC     = TIMEOUT_2MHZ_1S,
  parameter logic [MODE_W-1:0] DEFAULT_MODE    = {MODE_W{1'b0}}
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [MODE_W-1:0] iAdrMode,
  input  logic [CMPL_N-1:0] iAdrCmpl,
  input  logic [7:0]        iBiosPostCodes,
  input  logic              iSlpS5_n,
  input  logic              iAdrAck,
  input  logic              iRsmRst_n,
  output logic [MODE_W-1:0] oAdrMode,
  output logic [CMPL_N-1:0] oAdrCmpl,
  output logic              oAdrAck,
  output logic              oLatched,
  output logic [1:0]        oState,
  output logic              oTimeout
);

  localparam logic [7:0] STABLE = 8'(CODE_STABLE_CYC);

  adr_state_t        state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [MODE_W-1:0] mode_reg;
  logic              latched_reg;
  logic              rsm_s;
  logic              match, hit, capture, timeout_fire;

  adr_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_rsm_sync (
    .clk(iClk),
    .rst(iRst),
    .d  (iRsmRst_n),
    .q  (rsm_s)
  );

  // A saturated count still qualifies, so a code held across S5 exit latches at once.
  assign match    = (iBiosPostCodes == LATCH_CODE);
  assign hit      = match && (cnt_reg >= (STABLE - 8'd1));
  assign cnt_next = !match ? 8'd0 : ((cnt_reg == STABLE) ? cnt_reg : cnt_reg + 8'd1);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    if (!rsm_s) begin
      state_next = ST_RSM;
    end else begin
      case (state_reg)
        ST_RSM:   state_next = ST_WAIT;
        ST_WAIT: begin
          if (!iSlpS5_n) begin
            state_next = ST_S5;
          end else if (hit) begin
            capture    = 1'b1;
            state_next = ST_ARMED;
          end
        end
        ST_ARMED: if (!iSlpS5_n) state_next = ST_S5;
        ST_S5:    if (iSlpS5_n) state_next = ST_WAIT;
        default:  state_next = ST_RSM;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg   <= ST_RSM;
      cnt_reg     <= 8'd0;
      mode_reg    <= '0;
      latched_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        mode_reg    <= iAdrMode;
        latched_reg <= 1'b1;
      end else if (timeout_fire) begin
        mode_reg <= DEFAULT_MODE;
      end
    end
  end

`ifdef ADR_LATCH_TIMEOUT_EN
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYC - 1);

  logic [20:0] tcnt_reg;
  logic        timeout_reg;
  logic        stay_wait;

  // Counter holds at its last value so the default mode stays forced while waiting.
  assign stay_wait    = (state_reg == ST_WAIT) && (state_next == ST_WAIT);
  assign timeout_fire = stay_wait && (tcnt_reg == TO_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tcnt_reg    <= 21'd0;
      timeout_reg <= 1'b0;
    end else begin
      if (!stay_wait) begin
        tcnt_reg <= 21'd0;
      end else if (tcnt_reg != TO_LAST) begin
        tcnt_reg <= tcnt_reg + 21'd1;
      end
      if (capture) begin
        timeout_reg <= 1'b0;
      end else if (timeout_fire) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign oTimeout = timeout_reg;
`else
  logic cfg_unused;
  assign cfg_unused   = ^TIMEOUT_CYC;
  assign timeout_fire = 1'b0;
  assign oTimeout     = 1'b0;
`endif

  assign oAdrMode = mode_reg;
  assign oLatched = latched_reg;
  assign oState   = state_reg;
  assign oAdrAck  = rsm_s ? iAdrAck : 1'b1;
  assign oAdrCmpl = iAdrCmpl & {CMPL_N{state_reg == ST_ARMED}};

endmodule

// File: tb/tb_adr_latch_multi.sv
// Self-checking bench for adr_latch_multi: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the latch rules.
module tb_adr_latch_multi;

  localparam int         N_STABLE = 4;
  localparam int         S_STAGES = 2;
  localparam logic [7:0] CODE     = 8'hB0;
  localparam logic [1:0] DEF_MODE = 2'b00;
`ifdef ADR_LATCH_TIMEOUT_EN
  localparam int T_CYC = 100;
`else
  localparam int T_CYC = 2000000;
`endif

  logic       iClk = 1'b0;
  logic       iRst;
  logic [1:0] iAdrMode;
  logic [0:0] iAdrCmpl;
  logic [7:0] iBiosPostCodes;
  logic       iSlpS5_n, iAdrAck, iRsmRst_n;
  logic [1:0] oAdrMode;
  logic [0:0] oAdrCmpl;
  logic       oAdrAck, oLatched, oTimeout;
  logic [1:0] oState;

  adr_latch_multi #(
    .MODE_W(2), .CMPL_N(1), .LATCH_CODE(CODE), .CODE_STABLE_CYC(N_STABLE),
    .SYNC_STAGES(S_STAGES), .TIMEOUT_CYC(T_CYC), .DEFAULT_MODE(DEF_MODE)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iAdrMode(iAdrMode), .iAdrCmpl(iAdrCmpl),
    .iBiosPostCodes(iBiosPostCodes), .iSlpS5_n(iSlpS5_n), .iAdrAck(iAdrAck),
    .iRsmRst_n(iRsmRst_n), .oAdrMode(oAdrMode), .oAdrCmpl(oAdrCmpl),
    .oAdrAck(oAdrAck), .oLatched(oLatched), .oState(oState), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  // Behavioural model
  typedef enum int {M_RSM = 0, M_WAIT = 1, M_ARMED = 2, M_S5 = 3} mstate_t;
  mstate_t    m_state;
  logic       m_sh[S_STAGES];
  logic [7:0] m_hist[$];
  logic [1:0] m_mode;
  logic       m_latched, m_timeout;
  int         m_wait_age;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_RSM;
    for (int i = 0; i < S_STAGES; i++) m_sh[i] = 1'b0;
    m_hist.delete();
    m_mode = 2'b00;
    m_latched = 1'b0;
    m_timeout = 1'b0;
    m_wait_age = 0;
  endtask

  task automatic model_edge();
    logic    rsm_s, hit;
    mstate_t ns;
    rsm_s = m_sh[S_STAGES-1];
    // Capture qualifies when the last N samples, including this one, are all the code.
    m_hist.push_back(iBiosPostCodes);
    if (m_hist.size() > N_STABLE) void'(m_hist.pop_front());
    hit = (m_hist.size() == N_STABLE);
    foreach (m_hist[i]) if (m_hist[i] != CODE) hit = 1'b0;
    ns = m_state;
    if (!rsm_s) ns = M_RSM;
    else begin
      case (m_state)
        M_RSM: ns = M_WAIT;
        M_WAIT: begin
          if (!iSlpS5_n) ns = M_S5;
          else if (hit) begin
            ns = M_ARMED;
            m_mode = iAdrMode;
            m_latched = 1'b1;
            m_timeout = 1'b0;
          end
        end
        M_ARMED: if (!iSlpS5_n) ns = M_S5;
        M_S5: if (iSlpS5_n) ns = M_WAIT;
        default: ns = M_RSM;
      endcase
    end
`ifdef ADR_LATCH_TIMEOUT_EN
    if (m_state == M_WAIT && ns == M_WAIT) begin
      if (m_wait_age >= T_CYC - 1) begin
        m_mode = DEF_MODE;
        m_timeout = 1'b1;
      end
      m_wait_age++;
    end else begin
      m_wait_age = 0;
    end
`endif
    m_state = ns;
    for (int i = S_STAGES - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = iRsmRst_n;
  endtask

  task automatic check_all();
    check("state", 32'(oState), 32'(m_state));
    check("mode", 32'(oAdrMode), 32'(m_mode));
    check("latched", 32'(oLatched), 32'(m_latched));
    check("timeout", 32'(oTimeout), 32'(m_timeout));
    check("ack", 32'(oAdrAck), m_sh[S_STAGES-1] ? 32'(iAdrAck) : 32'd1);
    check("cmpl", 32'(oAdrCmpl), (m_state == M_ARMED) ? 32'(iAdrCmpl) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge iClk);
    model_edge();
    #1;
    check_all();
    ncyc++;
    $display("cyc %0d code=%02h slp=%0b rsm=%0b mode_in=%b st=%0d mode=%b lat=%0b to=%0b ack=%0b cmpl=%0b",
             ncyc, iBiosPostCodes, iSlpS5_n, iRsmRst_n, iAdrMode, oState, oAdrMode,
             oLatched, oTimeout, oAdrAck, oAdrCmpl);
  endtask

  task automatic do_reset();
    #2 iRst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_state", 32'(oState), 32'd0);
    check("arst_mode", 32'(oAdrMode), 32'd0);
    check("arst_latched", 32'(oLatched), 32'd0);
    check("arst_ack", 32'(oAdrAck), 32'd1);
    $display("async reset at t=%0t", $time);
    #3 iRst = 1'b0;
  endtask

  initial begin
    iRst = 1'b1; iRsmRst_n = 1'b0; iSlpS5_n = 1'b1; iBiosPostCodes = 8'h00;
    iAdrMode = 2'b00; iAdrCmpl = 1'b0; iAdrAck = 1'b0;
    model_reset();
    #3;
    check_all();
    check("rst_ack", 32'(oAdrAck), 32'd1);
    #4 iRst = 1'b0;

    // RSMRST# synchroniser and ACK gating
    iRsmRst_n = 1'b1;
    cycle(); check("ack_sync1", 32'(oAdrAck), 32'd1);
    cycle(); check("ack_follow", 32'(oAdrAck), 32'd0);
    iAdrAck = 1'b1; #1; check("ack_comb", 32'(oAdrAck), 32'd1);
    cycle(); check("st_wait", 32'(oState), 32'd1);

    // Code held too briefly: no capture, complete stays gated
    iAdrMode = 2'b10; iAdrCmpl = 1'b1;
    iBiosPostCodes = CODE; repeat (3) cycle();
    iBiosPostCodes = 8'h48; cycle();
    check("short_nolatch", 32'(oLatched), 32'd0);
    check("cmpl_gated", 32'(oAdrCmpl), 32'd0);

    // Full stable run: capture on the 4th edge
    iBiosPostCodes = CODE; repeat (3) cycle();
    check("precap_state", 32'(oState), 32'd1);
    cycle();
    check("cap_mode", 32'(oAdrMode), 32'h2);
    check("cap_latched", 32'(oLatched), 32'd1);
    check("cap_state", 32'(oState), 32'd2);
    check("cap_cmpl", 32'(oAdrCmpl), 32'd1);
    iAdrMode = 2'b01; cycle();
    check("no_recapture", 32'(oAdrMode), 32'h2);
    iSlpS5_n = 1'b0; cycle();
    check("s5_state", 32'(oState), 32'd3);
    check("s5_cmpl", 32'(oAdrCmpl), 32'd0);
    check("s5_mode_hold", 32'(oAdrMode), 32'h2);

    // Hit coinciding with SLP_S5# low, then capture on S5 exit
    iSlpS5_n = 1'b1; iBiosPostCodes = 8'h00; cycle();
    check("back_wait", 32'(oState), 32'd1);
    iBiosPostCodes = CODE; repeat (3) cycle();
    iSlpS5_n = 1'b0; cycle();
    check("simul_state", 32'(oState), 32'd3);
    check("simul_nocap", 32'(oAdrMode), 32'h2);
    iSlpS5_n = 1'b1; cycle();
    check("exit_wait", 32'(oState), 32'd1);
    cycle();
    check("exit_cap_mode", 32'(oAdrMode), 32'h1);
    check("exit_cap_state", 32'(oState), 32'd2);

`ifdef ADR_LATCH_TIMEOUT_EN
    iSlpS5_n = 1'b0; cycle();
    iSlpS5_n = 1'b1; iBiosPostCodes = 8'h00; cycle();
    repeat (T_CYC) cycle();
    check("to_flag", 32'(oTimeout), 32'd1);
    check("to_mode", 32'(oAdrMode), 32'(DEF_MODE));
    check("to_state", 32'(oState), 32'd1);
    iAdrMode = 2'b11; iBiosPostCodes = CODE; repeat (N_STABLE) cycle();
    check("to_clear", 32'(oTimeout), 32'd0);
    check("to_recap", 32'(oAdrMode), 32'h3);
`endif

    // Asynchronous reset while armed
    do_reset();

    // Randomised phase
    for (int n = 0; n < 600; n++) begin
      iBiosPostCodes = ($urandom_range(0, 9) < 7) ? CODE : 8'($urandom);
      if ($urandom_range(0, 15) == 0) iSlpS5_n = ~iSlpS5_n;
      else if (!iSlpS5_n && $urandom_range(0, 3) == 0) iSlpS5_n = 1'b1;
      iRsmRst_n = ($urandom_range(0, 39) != 0);
      iAdrMode = 2'($urandom);
      iAdrCmpl = 1'($urandom);
      iAdrAck = 1'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adr_latch_multi.md
Name: adr_latch_multi

Overview:
- Parametrised successor to the ADR mode/complete latch in the core CPLD ADR path.
- Captures MODE_W PCH ADR mode straps once a BIOS post code has been stable for a set number of cycles.
- Gates CMPL_N ADR-complete inputs from the PCH until capture, and re-arms across S5 cycles.
- Drives ADR ACK back to the PCH only after RSMRST# is synchronised high. Sits between PCH GPIO inputs and adr_fub.

Parameters:
- MODE_W, 2, number of ADR mode bits latched
- CMPL_N, 1, number of ADR-complete channels filtered
- LATCH_CODE, 8'hB0, BIOS post code that triggers capture
- CODE_STABLE_CYC, 4, consecutive matching samples required (range 1..255)
- SYNC_STAGES, 2, flops in the RSMRST# synchroniser (min 2)
- TIMEOUT_CYC, 2000000, WAIT-state timeout in clocks (1 s at 2 MHz); used only with the macro
- DEFAULT_MODE, {MODE_W{1'b0}}, mode value forced on timeout

Ports:
- iClk  in  1  2 MHz clock
- iRst  in  1  asynchronous, active-high reset
- iAdrMode  in  MODE_W  ADR mode GPIOs from PCH
- iAdrCmpl  in  CMPL_N  ADR complete GPIOs from PCH
- iBiosPostCodes  in  8  BIOS post code from BMC SGPIO
- iSlpS5_n  in  1  PCH SLP_S5#, synchronous to iClk
- iAdrAck  in  1  ADR ACK from adr_fub
- iRsmRst_n  in  1  PCH RSMRST#, asynchronous
- oAdrMode  out  MODE_W  latched modes
- oAdrCmpl  out  CMPL_N  filtered ADR complete
- oAdrAck  out  1  ACK to PCH
- oLatched  out  1  modes captured at least once since reset
- oState  out  2  FSM state, for debug
- oTimeout  out  1  sticky timeout flag

Behaviour:
- Reset (iRst=1, asynchronous) sets:
  - oAdrMode=0, oLatched=0, oTimeout=0
  - state=ST_RSM
  - synchroniser flops=0, so oAdrAck=1
  - stability counter=0
- RSMRST# passes through SYNC_STAGES flops; its output is rsm_s.
- oAdrAck = rsm_s ? iAdrAck : 1. Combinational from rsm_s; zero latency on iAdrAck.
- Stability counter (8-bit, saturating at CODE_STABLE_CYC):
  - Cleared on any cycle where iBiosPostCodes!=LATCH_CODE.
  - Otherwise increments.
  - hit = the match that brings the count to CODE_STABLE_CYC.
- FSM encodings: ST_RSM=0, ST_WAIT=1, ST_ARMED=2, ST_S5=3.
  - ST_RSM: go to ST_WAIT when rsm_s=1.
  - ST_WAIT:
    - iSlpS5_n=0 → ST_S5.
    - Else if hit: oAdrMode<=iAdrMode, oLatched<=1, oTimeout<=0, → ST_ARMED.
  - ST_ARMED: iSlpS5_n=0 → ST_S5. A further LATCH_CODE is ignored (no recapture).
  - ST_S5: iSlpS5_n=1 → ST_WAIT. The counter keeps running, so a stable code present on exit still latches.
- rsm_s falling in any state → ST_RSM. oAdrMode and oLatched are held.
- Simultaneous events: iSlpS5_n=0 takes priority over hit in the same cycle; no capture occurs.
- Latency: with CODE_STABLE_CYC=N, the code is first sampled at edge 1 and captured at edge N; outputs are valid after edge N.
- oAdrCmpl = iAdrCmpl & {CMPL_N{state==ST_ARMED}}. Combinational, zero latency; filtered in every other state.
- oAdrMode changes only on capture or timeout.

Optional Feature:
- Macro: ADR_LATCH_TIMEOUT_EN.
- Defined:
  - A 21-bit timeout counter runs only in ST_WAIT and clears on leaving ST_WAIT.
  - When the counter reaches TIMEOUT_CYC-1: oAdrMode<=DEFAULT_MODE, oTimeout<=1 (sticky).
  - oTimeout clears on reset or on the next successful capture.
  - The FSM stays in ST_WAIT; oLatched is unchanged.
- Not defined: no counter is built, oTimeout is tied 0, and ST_WAIT waits indefinitely.

Decomposition:
- Package adr_pkg holds:
  - state localparams ST_RSM/ST_WAIT/ST_ARMED/ST_S5 and the 2-bit state width
  - BIOS_LATCH_CODE_DEF=8'hB0
  - TIMEOUT_2MHZ_1S=2000000
- Sub-module adr_sync: a generic N-stage flop synchroniser (parameters STAGES, RST_VAL), instantiated for RSMRST#.

Test Plan:
- Reset, then raise iRsmRst_n → oAdrAck=1 until edge 2 after the rise, then follows iAdrAck; oState=1.
- In ST_WAIT, iAdrMode=2'b10, post code 8'hB0 for 4 cycles → oAdrMode=2'b10 after edge 4, oLatched=1, oState=2. Also hold 8'hB0 for only 3 cycles, then 8'h48 → no capture.
- Before capture iAdrCmpl=1 → oAdrCmpl=0. After capture iAdrCmpl=1 → oAdrCmpl=1 the same cycle. Then iSlpS5_n=0 → oAdrCmpl=0, oState=3, oAdrMode holds 2'b10.
- Hit and iSlpS5_n=0 in the same cycle → no capture, state ST_S5. iSlpS5_n=1 with 8'hB0 held → capture on the next cycle, since the count is already saturated.
- Toggle iRst mid-ST_ARMED → all outputs return to reset values immediately, asynchronously.
- With ADR_LATCH_TIMEOUT_EN and TIMEOUT_CYC=100: no code for 100 cycles → oAdrMode=DEFAULT_MODE, oTimeout=1. A later valid code → capture and oTimeout=0.
